// File: rtl/matrix_tile_buffer.sv
// ============================================================================
//  Module   : matrix_tile_buffer
//  Purpose  : DEPTH-entry tile store fed by the DRAM loader. It replays any
//             contiguous range of tiles over a valid/ready stream.
//             Optional macro TILE_BUF_PREFETCH_EN enables 1 tile/cycle replay.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module matrix_tile_buffer #(
    parameter int TILE_WIDTH = 256,
    parameter int DEPTH      = 64,
    localparam int AW        = $clog2(DEPTH),
    localparam int CW        = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [TILE_WIDTH-1:0] wr_data,
    input  logic                  wr_strobe,
    input  logic                  load_done,
    input  logic                  clear,
    output logic [CW-1:0]         count,
    output logic                  loaded,
    output logic                  overflow,
    input  logic                  rd_start,
    input  logic [AW-1:0]         rd_base,
    input  logic [CW-1:0]         rd_len,
    output logic                  rd_busy,
    output logic                  rd_error,
    output logic [TILE_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last
);

    localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_FETCH   = 2'd1,
        S_PRESENT = 2'd2
    } state_t;

    logic [TILE_WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic [CW-1:0]         r_remaining;
    logic                  r_loaded;
    logic                  r_overflow;
    logic                  r_rd_busy;
    logic                  r_rd_error;
    logic [TILE_WIDTH-1:0] r_out_data;
    logic                  r_out_valid;
    logic                  r_out_last;
    state_t                r_state;
    state_t                w_state_next;

    logic                  w_full;
    logic                  w_wr_en;
    logic                  w_hs;
    logic                  w_rd_ok;
    logic [AW+1:0]         w_rd_end;

    assign w_full   = (r_count == C_DEPTH);
    assign w_wr_en  = wr_strobe && !clear && !w_full;
    assign w_hs     = (r_state == S_PRESENT) && r_out_valid && out_ready;
    // Range end is formed two bits wider than an index so base+len never wraps.
    assign w_rd_end = (AW + 2)'(rd_base) + (AW + 2)'(rd_len);
    assign w_rd_ok  = r_loaded && (rd_len != '0) && (w_rd_end <= (AW + 2)'(r_count));

    assign count     = r_count;
    assign loaded    = r_loaded;
    assign overflow  = r_overflow;
    assign rd_busy   = r_rd_busy;
    assign rd_error  = r_rd_error;
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;

    // Tile storage is never reset or erased; clear only rewinds the pointers.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (rd_start && w_rd_ok) begin
                    w_state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                w_state_next = S_PRESENT;
            end
            S_PRESENT: begin
                if (w_hs) begin
`ifdef TILE_BUF_PREFETCH_EN
                    w_state_next = r_out_last ? S_IDLE : S_PRESENT;
`else
                    w_state_next = r_out_last ? S_IDLE : S_FETCH;
`endif
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
        if (clear) begin
            w_state_next = S_IDLE;
        end
    end

`ifdef TILE_BUF_PREFETCH_EN
    logic [TILE_WIDTH-1:0] r_stage;

    // Staging always holds mem[rd_ptr+1] so a non-last handshake can advance at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stage <= '0;
        end else if (r_state == S_FETCH) begin
            r_stage <= r_mem[r_rd_ptr + AW'(1)];
        end else if (w_hs && !r_out_last) begin
            r_stage <= r_mem[r_rd_ptr + AW'(2)];
        end
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_remaining <= '0;
            r_loaded    <= 1'b0;
            r_overflow  <= 1'b0;
            r_rd_busy   <= 1'b0;
            r_rd_error  <= 1'b0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else if (clear) begin
            r_wr_ptr    <= '0;
            r_count     <= '0;
            r_loaded    <= 1'b0;
            r_overflow  <= 1'b0;
            r_rd_error  <= 1'b0;
            r_rd_busy   <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            if (wr_strobe) begin
                if (w_full) begin
                    r_overflow <= 1'b1;
                end else begin
                    r_wr_ptr <= r_wr_ptr + AW'(1);
                    r_count  <= r_count + CW'(1);
                end
            end
            if (load_done) begin
                r_loaded <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (rd_start) begin
                        if (w_rd_ok) begin
                            r_rd_ptr    <= rd_base;
                            r_remaining <= rd_len;
                            r_rd_busy   <= 1'b1;
                        end else begin
                            r_rd_error  <= 1'b1;
                        end
                    end
                end
                S_FETCH: begin
                    r_out_valid <= 1'b1;
                    r_out_data  <= r_mem[r_rd_ptr];
                    r_out_last  <= (r_remaining == CW'(1));
                end
                S_PRESENT: begin
                    if (w_hs) begin
                        if (r_out_last) begin
                            r_out_valid <= 1'b0;
                            r_rd_busy   <= 1'b0;
                        end else begin
                            r_rd_ptr    <= r_rd_ptr + AW'(1);
                            r_remaining <= r_remaining - CW'(1);
`ifdef TILE_BUF_PREFETCH_EN
                            r_out_data  <= r_stage;
                            r_out_last  <= (r_remaining == CW'(2));
`else
                            r_out_valid <= 1'b0;
`endif
                        end
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/matrix_tile_buffer.md
# matrix_tile_buffer

On-chip tile store that sits directly downstream of the DRAM tile loader. It captures every tile strobed out by the loader into a DEPTH-entry buffer, marks the buffer loaded when the load burst ends, and then replays any contiguous range of stored tiles to the compute datapath over a valid/ready stream. The loader cannot be stalled, so the write side has no backpressure; overruns are flagged instead.

## Interface
- TILE_WIDTH, 256: bits per tile; multiple of 8.
- DEPTH, 64: tiles stored; power of 2, at least 2.
- clk  in  1  clock; all logic on posedge.
- rst  in  1  asynchronous, active-low reset.
- wr_data  in  TILE_WIDTH  tile from loader.
- wr_strobe  in  1  one-cycle pulse: capture wr_data.
- load_done  in  1  one-cycle pulse: loader burst finished.
- clear  in  1  synchronous flush of buffer contents state.
- count  out  $clog2(DEPTH+1)  tiles currently stored.
- loaded  out  1  set by load_done, cleared by clear.
- overflow  out  1  sticky: a strobe arrived while count==DEPTH.
- rd_start  in  1  pulse: begin replay.
- rd_base  in  $clog2(DEPTH)  first tile index of replay.
- rd_len  in  $clog2(DEPTH+1)  tiles to replay.
- rd_busy  out  1  replay in progress.
- rd_error  out  1  sticky: rejected rd_start.
- out_data  out  TILE_WIDTH  tile being presented.
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer accepts.
- out_last  out  1  qualifies final tile of replay.

## Operation
- Write: on wr_strobe with count<DEPTH, mem[wr_ptr]<=wr_data, wr_ptr++, count++. With count==DEPTH, tile dropped, overflow<=1, pointers unchanged.
- load_done sets loaded; further strobes still append. load_done and wr_strobe same cycle: tile stored and loaded set.
- clear: wr_ptr, count, loaded, overflow, rd_error <=0; aborts any replay (FSM->IDLE, out_valid<=0, rd_busy<=0). clear beats wr_strobe, load_done, rd_start in the same cycle. Memory contents are not erased.
- Replay FSM: IDLE, FETCH, PRESENT.
- IDLE: rd_start accepted only if loaded==1, rd_len!=0 and rd_base+rd_len<=count (compare at $clog2(DEPTH)+2 bits, no wrap). Otherwise rd_error<=1, stay IDLE. Accepted: rd_ptr<=rd_base, remaining<=rd_len, rd_busy<=1, go FETCH. rd_start outside IDLE ignored, no error.
- FETCH: synchronous memory read of mem[rd_ptr]; go PRESENT with out_valid<=1, out_data<=read data, out_last<=(remaining==1).
- PRESENT: out_data/out_last held stable while out_valid && !out_ready. On handshake: if out_last, out_valid<=0, rd_busy<=0, go IDLE; else rd_ptr++, remaining--, out_valid<=0, go FETCH.
- Writes during replay allowed; range was validated at start. Read and write of the same address in one cycle returns the old data.
- Byte order: element k of a tile occupies bits [8k+7:8k]; buffer never reorders bits.

## Timing
- Reset: count, loaded, overflow, rd_busy, rd_error, out_valid, out_last = 0; out_data = 0; FSM IDLE; pointers 0.
- wr_strobe at cycle T -> count updated at T+1; tile readable by a replay starting at T+1.
- rd_start at T -> rd_busy high at T+1 (FETCH) -> out_valid high at T+2.
- Handshake at H (not last) -> next out_valid at H+2: one tile per 2 cycles.
- Final handshake at H -> rd_busy, out_valid low at H+1; new rd_start accepted at H+1.
- rd_error / overflow set the cycle after the offending event; held until clear or reset.

## Configuration
- TILE_BUF_PREFETCH_EN defined: in PRESENT the read of mem[rd_ptr+1] is issued ahead into a staging register; on a non-last handshake at H the next tile is presented at H+1, out_valid stays high, full 1 tile/cycle throughput. First-tile latency unchanged (T+2).
- Undefined: no staging register; behaviour exactly as in Operation (2 cycles per tile).

## Test plan
- Reset mid-replay (rst low during PRESENT) -> all outputs 0 immediately, count 0, next rd_start with loaded==0 -> rd_error=1.
- 4 strobes of 0x11..,0x22..,0x33..,0x44.. then load_done; rd_start base=1 len=2, out_ready=1 -> 0x22.. then 0x33.. with out_last on second, rd_busy drops after.
- DEPTH=4, 5 strobes -> count=4, overflow=1, mem[0..3] = first four tiles.
- rd_start base=3 len=2 with count=4 -> rd_error=1, no out_valid; len=0 -> rd_error=1.
- out_ready low 5 cycles in PRESENT -> out_data/out_last stable, single transfer when raised; clear during stall -> out_valid=0 next cycle, count=0.
- With TILE_BUF_PREFETCH_EN, 8-tile replay, out_ready=1 -> 8 consecutive out_valid cycles starting T+2; without it 15 cycles from first to last.
